flit_tx_port: RTL and testbench

//  Upstream (transmit) end of the router-to-router link feeding a downstream input_port.

---
 rtl/flit_tx_port.sv | 250 +++++++++++++++++++++++++
 tb/tb_flit_tx_port.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/flit_tx_port.sv
// flit_tx_port: transmit end of a router-to-router link.
// Per-VC staging FIFOs with HEAD->BODY*->TAIL admission checking, a
// round-robin VC arbiter honouring downstream on/off flow control, and a
// registered one-flit-per-cycle link output.
// Optional feature macro: TX_PKT_LOCK_EN. When defined, the arbiter locks
// onto a VC from a granted HEAD until that VC's TAIL has been sent.

package noc_params;
  localparam int VC_NUM    = 4;                // must be a power of two
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int DATA_SIZE = 8;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t            flit_label;
    logic [VC_SIZE-1:0]     vc_id;
    logic [DATA_SIZE-1:0]   data;
  } flit_t;
endpackage

module flit_tx_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             data_i,
  input  logic              valid_flit_i,
  input  logic [VC_NUM-1:0] on_off_i,
  output flit_t             data_o,
  output logic              valid_flit_o,
  output logic [VC_NUM-1:0] is_full_o,
  output logic [VC_NUM-1:0] is_empty_o,
  output logic              drop_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_t;

  // Per-VC storage and bookkeeping
  flit_t            mem_r        [VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0] wr_ptr_r     [VC_NUM];
  logic [PTR_W-1:0] rd_ptr_r     [VC_NUM];
  logic [CNT_W-1:0] cnt_r        [VC_NUM];
  logic [CNT_W-1:0] cnt_next_s   [VC_NUM];
  vc_state_t        state_r      [VC_NUM];
  vc_state_t        state_next_s [VC_NUM];
  logic [VC_NUM-1:0] full_r, empty_r;
  logic [VC_NUM-1:0] push_s, pop_s;

  // Write side
  logic [VC_SIZE-1:0] wr_vc_s;
  logic               accept_s, drop_s;

  // Arbiter and link
  logic [VC_NUM-1:0]  eligible_s;
  logic               rr_valid_s, grant_valid_s;
  logic [VC_SIZE-1:0] rr_grant_s, grant_s;
  logic [VC_SIZE-1:0] rr_ptr_r, rr_ptr_next_s;
  flit_t              head_flit_s;
  flit_t              data_r;
  logic               valid_r, drop_r;

`ifdef TX_PKT_LOCK_EN
  logic               lock_r, lock_next_s;
  logic [VC_SIZE-1:0] lock_vc_r, lock_vc_next_s;
`endif

  // Next VC index after v, wrapping at VC_NUM.
  function automatic logic [VC_SIZE-1:0] vc_inc(input logic [VC_SIZE-1:0] v);
    return (int'(v) == VC_NUM - 1) ? VC_SIZE'(0) : v + VC_SIZE'(1);
  endfunction

  assign head_flit_s  = mem_r[grant_s][rd_ptr_r[grant_s]];
  assign data_o       = data_r;
  assign valid_flit_o = valid_r;
  assign drop_o       = drop_r;
  assign is_full_o    = full_r;
  assign is_empty_o   = empty_r;

  // Admission: accept or drop the incoming flit against its VC's packet state.
  always_comb begin
    wr_vc_s  = data_i.vc_id;
    accept_s = 1'b0;
    drop_s   = 1'b0;
    for (int v = 0; v < VC_NUM; v++) state_next_s[v] = state_r[v];
    if (valid_flit_i) begin
      if (full_r[wr_vc_s]) begin
        // A pop in the same cycle does not make room for this flit.
        drop_s = 1'b1;
      end else begin
        case (state_r[wr_vc_s])
          IDLE: begin
            case (data_i.flit_label)
              HEAD:     begin accept_s = 1'b1; state_next_s[wr_vc_s] = ACTIVE; end
              HEADTAIL: accept_s = 1'b1;
              default:  drop_s   = 1'b1;
            endcase
          end
          ACTIVE: begin
            case (data_i.flit_label)
              BODY:    accept_s = 1'b1;
              TAIL:    begin accept_s = 1'b1; state_next_s[wr_vc_s] = IDLE; end
              default: drop_s   = 1'b1;
            endcase
          end
          default: drop_s = 1'b1;
        endcase
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Round-robin search: first eligible VC at or after rr_ptr, with wrap.
  always_comb begin
    logic [VC_SIZE-1:0] idx;
    idx        = VC_SIZE'(0);
    eligible_s = ~empty_r & on_off_i;
    rr_valid_s = 1'b0;
    rr_grant_s = rr_ptr_r;
    // Walk from the farthest offset down so the nearest eligible VC wins.
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      idx        = rr_ptr_r + VC_SIZE'(i);
      rr_grant_s = eligible_s[idx] ? idx : rr_grant_s;
      rr_valid_s = rr_valid_s | eligible_s[idx];
    end
  end

  // Final grant selection and pointer/lock update.
  always_comb begin
    rr_ptr_next_s = rr_ptr_r;
`ifdef TX_PKT_LOCK_EN
    lock_next_s    = lock_r;
    lock_vc_next_s = lock_vc_r;
    if (lock_r) begin
      // Locked VC only; a blocked locked VC stalls the whole link.
      grant_valid_s = eligible_s[lock_vc_r];
      grant_s       = lock_vc_r;
    end else begin
      grant_valid_s = rr_valid_s;
      grant_s       = rr_grant_s;
    end
    if (grant_valid_s) begin
      if (lock_r) begin
        if (head_flit_s.flit_label == TAIL) begin
          lock_next_s   = 1'b0;
          rr_ptr_next_s = vc_inc(grant_s);
        end else begin
          lock_next_s = 1'b1;
        end
      end else if (head_flit_s.flit_label == HEAD) begin
        lock_next_s    = 1'b1;
        lock_vc_next_s = grant_s;
      end else begin
        rr_ptr_next_s = vc_inc(grant_s);
      end
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
`else
    grant_valid_s = rr_valid_s;
    grant_s       = rr_grant_s;
    if (grant_valid_s) begin
      rr_ptr_next_s = vc_inc(grant_s);
    end else begin
      rr_ptr_next_s = rr_ptr_r;
    end
`endif
  end

  // Per-VC push/pop decode and next occupancy.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      push_s[v] = accept_s && (int'(wr_vc_s) == v);
      pop_s[v]  = grant_valid_s && (int'(grant_s) == v);
      case ({push_s[v], pop_s[v]})
        2'b10:   cnt_next_s[v] = cnt_r[v] + CNT_W'(1);
        2'b01:   cnt_next_s[v] = cnt_r[v] - CNT_W'(1);
        default: cnt_next_s[v] = cnt_r[v];
      endcase
    end
  end

  // FIFO storage write; contents need no reset because pointers gate them.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_vc_s][wr_ptr_r[wr_vc_s]] <= data_i;
    end
  end

  // FIFO pointers, occupancy, status flags and packet state per VC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_r[v] <= PTR_W'(0);
        rd_ptr_r[v] <= PTR_W'(0);
        cnt_r[v]    <= CNT_W'(0);
        state_r[v]  <= IDLE;
      end
      full_r  <= {VC_NUM{1'b0}};
      empty_r <= {VC_NUM{1'b1}};
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push_s[v]) wr_ptr_r[v] <= wr_ptr_r[v] + PTR_W'(1);
        if (pop_s[v])  rd_ptr_r[v] <= rd_ptr_r[v] + PTR_W'(1);
        cnt_r[v]   <= cnt_next_s[v];
        state_r[v] <= state_next_s[v];
        full_r[v]  <= (cnt_next_s[v] == CNT_W'(BUFFER_SIZE));
        empty_r[v] <= (cnt_next_s[v] == CNT_W'(0));
      end
    end
  end

  // Link output register, drop pulse and arbiter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= '0;
      valid_r  <= 1'b0;
      drop_r   <= 1'b0;
      rr_ptr_r <= VC_SIZE'(0);
`ifdef TX_PKT_LOCK_EN
      lock_r    <= 1'b0;
      lock_vc_r <= VC_SIZE'(0);
`endif
    end else begin
      valid_r  <= grant_valid_s;
      drop_r   <= drop_s;
      rr_ptr_r <= rr_ptr_next_s;
      if (grant_valid_s) data_r <= head_flit_s;
`ifdef TX_PKT_LOCK_EN
      lock_r    <= lock_next_s;
      lock_vc_r <= lock_vc_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_flit_tx_port.sv
// Directed self-checking bench for flit_tx_port (default build; expectations
// for the arbitration test also cover TX_PKT_LOCK_EN).
`timescale 1ns/1ps
module tb_flit_tx_port;
  import noc_params::*;

  logic              clk = 1'b0;
  logic              rst;
  flit_t             data_i;
  logic              valid_flit_i;
  logic [VC_NUM-1:0] on_off_i;
  flit_t             data_o;
  logic              valid_flit_o;
  logic [VC_NUM-1:0] is_full_o;
  logic [VC_NUM-1:0] is_empty_o;
  logic              drop_o;

  int n_checks = 0;
  int n_fail   = 0;

  flit_t in_q[$];
  bit    exp_v_q[$];
  flit_t exp_d_q[$];
  bit    exp_drop_q[$];
  flit_t nf;
  flit_t exp_f;
  flit_t pkt_q[$];

  flit_tx_port #(.BUFFER_SIZE(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .on_off_i(on_off_i), .data_o(data_o), .valid_flit_o(valid_flit_o),
    .is_full_o(is_full_o), .is_empty_o(is_empty_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input flit_label_t l, input logic [VC_SIZE-1:0] vc,
                               input logic [DATA_SIZE-1:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc;
    f.data       = d;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input flit_t f);
    valid_flit_i = v;
    data_i       = f;
    tick();
  endtask

  // Drives in_q back-to-back, then idles; index i checks the state after the i-th edge.
  task automatic run_seq(input string tag);
    for (int i = 0; i < exp_v_q.size(); i++) begin
      if (i < in_q.size()) drive(1'b1, in_q[i]);
      else                 drive(1'b0, nf);
      check($sformatf("%s valid[%0d]", tag, i), 32'(valid_flit_o), 32'(exp_v_q[i]));
      check($sformatf("%s drop[%0d]", tag, i), 32'(drop_o), 32'(exp_drop_q[i]));
      if (exp_v_q[i]) check($sformatf("%s data[%0d]", tag, i), 32'(data_o), 32'(exp_d_q[i]));
    end
    in_q.delete(); exp_v_q.delete(); exp_d_q.delete(); exp_drop_q.delete();
  endtask

  initial begin
    nf = '0;

    // 1: reset with valid input held high
    rst = 1'b1; valid_flit_i = 1'b1; data_i = mk(HEAD, 2'd0, 8'h55); on_off_i = 4'hF;
    tick(); tick();
    check("rst valid", 32'(valid_flit_o), 32'd0);
    check("rst drop",  32'(drop_o),       32'd0);
    check("rst empty", 32'(is_empty_o),   32'hF);
    check("rst full",  32'(is_full_o),    32'h0);
    check("rst data",  32'(data_o),       32'h0);
    rst = 1'b0;
    drive(1'b0, nf);
    drive(1'b0, nf);
    check("post-rst valid", 32'(valid_flit_o), 32'd0);
    check("post-rst empty", 32'(is_empty_o),   32'hF);

    // 2: single packet on VC0, latency 2, one flit per cycle
    in_q       = '{mk(HEAD,2'd0,8'hA0), mk(BODY,2'd0,8'hA1), mk(BODY,2'd0,8'hA2), mk(TAIL,2'd0,8'hA3)};
    exp_v_q    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d_q    = '{nf, in_q[0], in_q[1], in_q[2], in_q[3], nf};
    exp_drop_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_seq("pkt");
    check("pkt hold data", 32'(data_o),     32'(mk(TAIL,2'd0,8'hA3)));
    check("pkt empty",     32'(is_empty_o), 32'hF);

    // 3: BODY/TAIL on idle VC1 are dropped
    in_q       = '{mk(BODY,2'd1,8'hB0), mk(TAIL,2'd1,8'hB1)};
    exp_v_q    = '{1'b0, 1'b0, 1'b0};
    exp_d_q    = '{nf, nf, nf};
    exp_drop_q = '{1'b1, 1'b1, 1'b0};
    run_seq("idle-drop");
    check("idle-drop empty", 32'(is_empty_o), 32'hF);

    // 4: repeated HEADs are dropped and never forwarded
    in_q       = '{mk(HEAD,2'd0,8'hC0), mk(HEAD,2'd0,8'hC1), mk(HEAD,2'd0,8'hC2),
                   mk(BODY,2'd0,8'hC3), mk(TAIL,2'd0,8'hC4)};
    exp_v_q    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_d_q    = '{nf, in_q[0], nf, nf, in_q[3], in_q[4], nf};
    exp_drop_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    run_seq("rehead");

    // 5: fill VC0 while blocked, overflow drop, then drain 8 flits
    on_off_i = 4'b1110;
    pkt_q.delete();
    for (int i = 0; i < 9; i++) begin
      exp_f = mk((i == 0) ? HEAD : BODY, 2'd0, 8'(8'hD0 + i));
      pkt_q.push_back(exp_f);
      drive(1'b1, exp_f);
      check($sformatf("fill full[%0d]", i), 32'(is_full_o[0]), (i >= 7) ? 32'd1 : 32'd0);
      check($sformatf("fill drop[%0d]", i), 32'(drop_o),       (i == 8) ? 32'd1 : 32'd0);
      check($sformatf("fill valid[%0d]", i), 32'(valid_flit_o), 32'd0);
    end
    // Unblock and write to the full VC in the same cycle: still dropped.
    on_off_i = 4'hF;
    for (int i = 0; i < 9; i++) begin
      drive(i == 0, mk(BODY, 2'd0, 8'hEE));
      check($sformatf("drain valid[%0d]", i), 32'(valid_flit_o), (i < 8) ? 32'd1 : 32'd0);
      check($sformatf("drain drop[%0d]", i),  32'(drop_o),       (i == 0) ? 32'd1 : 32'd0);
      if (i < 8) check($sformatf("drain data[%0d]", i), 32'(data_o), 32'(pkt_q[i]));
    end
    check("drain empty", 32'(is_empty_o), 32'hF);
    in_q       = '{mk(TAIL,2'd0,8'hDF)};
    exp_v_q    = '{1'b0, 1'b1, 1'b0};
    exp_d_q    = '{nf, in_q[0], nf};
    exp_drop_q = '{1'b0, 1'b0, 1'b0};
    run_seq("close");

    // Reset mid-packet flushes buffered flits and VC state
    on_off_i = 4'b1011;
    drive(1'b1, mk(HEAD, 2'd2, 8'h20));
    drive(1'b1, mk(BODY, 2'd2, 8'h21));
    check("mid empty2", 32'(is_empty_o[2]), 32'd0);
    rst = 1'b1;
    drive(1'b0, nf);
    rst = 1'b0;
    check("mid rst empty", 32'(is_empty_o), 32'hF);
    on_off_i   = 4'hF;
    in_q       = '{mk(BODY,2'd2,8'h22)};
    exp_v_q    = '{1'b0, 1'b0, 1'b0};
    exp_d_q    = '{nf, nf, nf};
    exp_drop_q = '{1'b1, 1'b0, 1'b0};
    run_seq("mid flushed");

    // 6: two pending 2-flit packets on VC0 and VC1, rr_ptr = 0
    on_off_i = 4'h0;
    drive(1'b1, mk(HEAD, 2'd0, 8'h60));
    drive(1'b1, mk(TAIL, 2'd0, 8'h61));
    drive(1'b1, mk(HEAD, 2'd1, 8'h70));
    drive(1'b1, mk(TAIL, 2'd1, 8'h71));
    valid_flit_i = 1'b0;
    on_off_i     = 4'hF;
`ifdef TX_PKT_LOCK_EN
    pkt_q = '{mk(HEAD,2'd0,8'h60), mk(TAIL,2'd0,8'h61), mk(HEAD,2'd1,8'h70), mk(TAIL,2'd1,8'h71)};
`else
    pkt_q = '{mk(HEAD,2'd0,8'h60), mk(HEAD,2'd1,8'h70), mk(TAIL,2'd0,8'h61), mk(TAIL,2'd1,8'h71)};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, nf);
      check($sformatf("rr valid[%0d]", i), 32'(valid_flit_o), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) check($sformatf("rr data[%0d]", i), 32'(data_o), 32'(pkt_q[i]));
    end

    // HEADTAIL keeps VC3 idle, so a following BODY is dropped
    in_q       = '{mk(HEADTAIL,2'd3,8'h30), mk(HEADTAIL,2'd3,8'h31), mk(BODY,2'd3,8'h32)};
    exp_v_q    = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_d_q    = '{nf, in_q[0], in_q[1], nf};
    exp_drop_q = '{1'b0, 1'b0, 1'b1, 1'b0};
    run_seq("headtail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
